shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shares the design's single 16-bit left-rotator datapath between two requesters, e.g. the execute stage and the debug/CRC unit. It arbitrates round-robin and translates each request's opcode (ROL, SLL, ROR, SRA) into a left-rotate amount plus a fill mask. It returns the result through one registered response channel tagged with the requester ID. It sits beside the ALU and is the only user of the rotator instance.

## Interface
- `WIDTH`, 16: data width; only 16 is supported.
- `CNT_W`, 4: shift-count width; must equal log2(`WIDTH`).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset; **asynchronous, active-low**.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0's operation is accepted this cycle.
- `req0_op` in 2: operation code, 00 ROL, 01 SLL, 10 ROR, 11 SRA.
- `req0_data` in 16: operand.
- `req0_cnt` in 4: shift/rotate amount, 0–15.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_data`, `req1_cnt`: same set of ports for requester 1.
- `rsp_valid` out 1: result register holds a valid result.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_id` out 1: which requester issued the result.
- `rsp_data` out 16: result.

## Operation
- **Transfers.** A request transfers on `reqN_valid & reqN_ready`. A response transfers on `rsp_valid & rsp_ready`.
- **Free slot.** `slot_free = !rsp_valid | rsp_ready`.
- **Grant.**
  - Only one requester valid: it is granted.
  - Both valid: the requester selected by the priority pointer `prio` is granted.
  - `reqN_ready = slot_free & grant==N`. At most one ready is high per cycle, and only while `slot_free`.
  - `reqN_ready` depends combinationally on both `reqN_valid` and `rsp_ready`, with no path back to `rsp_ready`.
- **Priority pointer.** On each accepted request, `prio` moves to the *other* requester. With no accept, `prio` holds.
- **Rotate amount.** ROL and SLL rotate left by `cnt`. ROR and SRA rotate left by `(16 - cnt) mod 16`, computed in 4 bits, so cnt=0 rotates by 0.
- **Masking after the rotate.**
  - ROL, ROR: no mask.
  - SLL: bits [cnt-1:0] are forced to 0.
  - SRA: bits [15:16-cnt] are forced to `data[15]`.
  - cnt=0: every op returns `data` unchanged.
- **Result register.** On accept, the masked result and the granted ID load into `rsp_data` and `rsp_id`, and `rsp_valid` sets.
  - On a response transfer with no new accept, `rsp_valid` clears.
  - On a response transfer and an accept in the same cycle, the register reloads and `rsp_valid` stays 1.
- **Hold under stall.** While `rsp_valid & !rsp_ready`:
  - `rsp_data` and `rsp_id` are held stable;
  - both readies are 0;
  - requesters must hold their request stable while valid is high and ready is low.
- **Reset.** The asynchronous assertion of `rst_n` forces the following immediately:
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `prio`=0;
  - both readies go to 0 via `grant`/`slot_free` gating, and idle readies are 0.
  - A request or response in flight is discarded; no partial result survives.
  - Deassertion takes effect at the next `clk` edge.

## Timing
- Latency: accept at edge N puts the result on `rsp_data`, with `rsp_valid`=1, after edge N, i.e. 1 cycle.
- Throughput: 1 op/cycle while `rsp_ready`=1. Two requesters both continuously valid alternate 0,1,0,1…
- Starvation bound: a valid requester is granted within 2 accepts.
- Rotator and mask are combinational between the input mux and the result register. No other registers.

## Structure
- **Shared package `shift_pkg`:**
  - `op_t` enum: ROL=2'b00, SLL=2'b01, ROR=2'b10, SRA=2'b11;
  - `WIDTH`/`CNT_W` constants;
  - a function for the 4-bit two's-complement amount.
- **Sub-module `lrotator16`:** the existing 4-stage left-rotator (In, Cnt, Out), instantiated once. The mask logic lives in `shift_arbiter`.

## Test plan
- **Reset and idle.** Assert `rst_n`=0 mid-run with `rsp_valid`=1 → outputs are 0 immediately, `rsp_valid`=0. After release with no valid inputs, both readies stay 0.
- **Opcode sweep.** Each from requester 0, with `rsp_ready`=1; each result appears 1 cycle later with `rsp_id`=0:
  - ROL 0x8001 cnt1 → 0x0003
  - SLL 0x8001 cnt1 → 0x0002
  - ROR 0x0001 cnt4 → 0x1000
  - SRA 0x8000 cnt15 → 0xFFFF
  - SRA 0x4000 cnt14 → 0x0001
  - any op with cnt0 → operand unchanged
- **Contention.** Both requesters continuously valid for 6 cycles from reset → grant order 0,1,0,1,0,1, `rsp_id` sequence matching, one result per cycle.
- **Backpressure.** `rsp_ready`=0 for 3 cycles while holding result 0x1234 → `rsp_data` stays 0x1234 and both readies are 0. On `rsp_ready`=1, the waiting request is accepted in the same cycle and its result appears the next cycle.
- **Single requester.** Only requester 1 valid for 4 cycles → accepted every cycle despite `prio` toggling.
- **Random check.** Random ops/cnts/backpressure versus a reference model → exact data/ID match, no lost or duplicated transfers.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg -- shared types and helpers for the shift arbiter slice.
//   WIDTH / CNT_W : datapath width (16) and shift-count width (log2(WIDTH)).
//   op_t          : request opcode (ROL, SLL, ROR, SRA).
//   neg_amt()     : 4-bit two's complement of a count, turning a right
//                   rotate into the equivalent left rotate.
// ---------------------------------------------------------------------------
package shift_pkg;

   localparam int WIDTH = 16;
   localparam int CNT_W = 4;

   typedef logic [WIDTH-1:0] data_t;
   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      ROL = 2'b00,
      SLL = 2'b01,
      ROR = 2'b10,
      SRA = 2'b11
   } op_t;

   // (WIDTH - cnt) mod WIDTH; wraps naturally in CNT_W bits, so 0 maps to 0.
   function automatic cnt_t neg_amt(cnt_t cnt);
      return ~cnt + cnt_t'(1);
   endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// ---------------------------------------------------------------------------
// shift_arbiter_if -- two request channels plus one response channel.
//   req0_* / req1_* : valid/ready handshake with op, operand and count.
//   rsp_*           : valid/ready handshake with requester id and result.
//   master : requester/consumer side.   slave : the arbiter.
// ---------------------------------------------------------------------------
interface shift_arbiter_if;
   import shift_pkg::*;

   logic  req0_valid;
   logic  req0_ready;
   op_t   req0_op;
   data_t req0_data;
   cnt_t  req0_cnt;

   logic  req1_valid;
   logic  req1_ready;
   op_t   req1_op;
   data_t req1_data;
   cnt_t  req1_cnt;

   logic  rsp_valid;
   logic  rsp_ready;
   logic  rsp_id;
   data_t rsp_data;

   modport master (
      output req0_valid, req0_op, req0_data, req0_cnt,
      input  req0_ready,
      output req1_valid, req1_op, req1_data, req1_cnt,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_data,
      output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_op, req0_data, req0_cnt,
      output req0_ready,
      input  req1_valid, req1_op, req1_data, req1_cnt,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_data,
      input  rsp_ready
   );

endinterface

// File: rtl/shift_arbiter_lrotator16.sv
// ---------------------------------------------------------------------------
// lrotator16 -- purely combinational 16-bit left rotator, four log stages.
//   data_in  : operand
//   cnt      : rotate-left amount, 0..15
//   data_out : data_in rotated left by cnt
// ---------------------------------------------------------------------------
module lrotator16
   import shift_pkg::*;
(
   input  data_t data_in,
   input  cnt_t  cnt,
   output data_t data_out
);

   data_t s0, s1, s2;

   assign s0       = cnt[0] ? {data_in[14:0], data_in[15]}    : data_in;
   assign s1       = cnt[1] ? {s0[13:0],      s0[15:14]}      : s0;
   assign s2       = cnt[2] ? {s1[11:0],      s1[15:12]}      : s1;
   assign data_out = cnt[3] ? {s2[7:0],       s2[15:8]}       : s2;

endmodule

// File: rtl/shift_arbiter.sv
// ---------------------------------------------------------------------------
// shift_arbiter -- round-robin share of one left rotator between two
// requesters, with a single registered response slot.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : shift_arbiter_if.slave (req0_*, req1_*, rsp_*)
// Every op is mapped onto a left rotate plus a fill mask:
//   ROL/SLL rotate by cnt, ROR/SRA by (16-cnt) mod 16; SLL clears the low
//   cnt bits, SRA fills the top cnt bits with the operand sign.
// ---------------------------------------------------------------------------
module shift_arbiter
   import shift_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   shift_arbiter_if.slave bus
);

   // Arbitration
   logic  slot_free;
   logic  any_valid;
   logic  grant;
   logic  accept;

   // Datapath
   op_t   sel_op;
   data_t sel_data;
   cnt_t  sel_cnt;
   cnt_t  rot_amt;
   data_t rot_out;
   data_t lo_mask;
   data_t hi_mask;
   data_t result;

   // State
   logic  prio_q;
   logic  rsp_valid_q;
   logic  rsp_id_q;
   data_t rsp_data_q;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      // Gating with rst_n keeps both readies low for the whole reset
      // window, so no request can be "accepted" and then dropped.
      slot_free = rst_n & (~rsp_valid_q | bus.rsp_ready);
      any_valid = bus.req0_valid | bus.req1_valid;
      grant     = bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) begin
         grant = prio_q;
      end
      accept    = slot_free & any_valid;
   end

   assign bus.req0_ready = accept & ~grant;
   assign bus.req1_ready = accept &  grant;

   always_comb begin
      sel_op   = grant ? bus.req1_op   : bus.req0_op;
      sel_data = grant ? bus.req1_data : bus.req0_data;
      sel_cnt  = grant ? bus.req1_cnt  : bus.req0_cnt;

      rot_amt = sel_cnt;
      if (sel_op == ROR || sel_op == SRA) begin
         rot_amt = neg_amt(sel_cnt);
      end
   end

   lrotator16 u_rot (
      .data_in  (sel_data),
      .cnt      (rot_amt),
      .data_out (rot_out)
   );

   always_comb begin
      // lo_mask: bits [cnt-1:0]; hi_mask: bits [15:16-cnt]; both empty at cnt=0.
      lo_mask = (data_t'(1) << sel_cnt) - data_t'(1);
      hi_mask = ~({WIDTH{1'b1}} >> sel_cnt);
      result  = rot_out;
      case (sel_op)
         SLL:     result = rot_out & ~lo_mask;
         SRA:     result = (rot_out & ~hi_mask) |
                           (hi_mask & {WIDTH{sel_data[WIDTH-1]}});
         default: result = rot_out;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
      end else if (accept) begin
         // Loading also covers the simultaneous drain-and-refill case.
         prio_q      <= ~grant;
         rsp_valid_q <= 1'b1;
         rsp_id_q    <= grant;
         rsp_data_q  <= result;
      end else if (rsp_valid_q && bus.rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shift_arbiter -- directed scenarios plus a randomized run against a
// behavioural model of the shift arbiter.
// ---------------------------------------------------------------------------
module tb_shift_arbiter;
   import shift_pkg::*;

   logic clk;
   logic rst_n;

   int checks;
   int passed;

   shift_arbiter_if bus ();

   shift_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result computed bit by bit / with plain operators.
   function automatic data_t ref_result(op_t op, data_t d, cnt_t c);
      data_t o;
      int    n;
      n = int'(c);
      o = '0;
      case (op)
         ROL: for (int i = 0; i < 16; i++) o[(i + n) % 16] = d[i];
         SLL: o = d << n;
         ROR: for (int i = 0; i < 16; i++) o[i] = d[(i + n) % 16];
         SRA: o = $signed(d) >>> n;
         default: o = '0;
      endcase
      return o;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req0_valid = 1'b0;
      bus.req0_op    = ROL;
      bus.req0_data  = '0;
      bus.req0_cnt   = '0;
      bus.req1_valid = 1'b0;
      bus.req1_op    = ROL;
      bus.req1_data  = '0;
      bus.req1_cnt   = '0;
      bus.rsp_ready  = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #2;
      bus.req0_valid = 1'b1;
      bus.rsp_ready  = 1'b1;
      #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== 18'd0)
         $display("FAIL reset_outputs got v=%b id=%b d=%h exp all 0",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_data);
      else passed++;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b00)
         $display("FAIL reset_readies got %b%b exp 00", bus.req1_ready, bus.req0_ready);
      else passed++;
      bus.req0_valid = 1'b0;
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({bus.req1_ready, bus.req0_ready, bus.rsp_valid} !== 3'b000)
            $display("FAIL idle_after_reset[%0d] got r1=%b r0=%b v=%b exp 0 0 0",
                     i, bus.req1_ready, bus.req0_ready, bus.rsp_valid);
         else passed++;
      end
   endtask

   task automatic test_reset_midrun();
      bus.rsp_ready  = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req0_op    = ROL;
      bus.req0_data  = 16'hABCD;
      bus.req0_cnt   = 4'd0;
      tick();
      bus.req0_valid = 1'b0;
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hABCD)
         $display("FAIL midrun_load got v=%b d=%h exp 1 abcd", bus.rsp_valid, bus.rsp_data);
      else passed++;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== 18'd0)
         $display("FAIL midrun_reset got v=%b id=%b d=%h exp all 0",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_data);
      else passed++;
      bus.req1_valid = 1'b1;
      #1;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b00)
         $display("FAIL midrun_reset_ready got %b%b exp 00", bus.req1_ready, bus.req0_ready);
      else passed++;
      bus.req1_valid = 1'b0;
      #1;
      rst_n = 1'b1;
      tick();
      checks++;
      if ({bus.req1_ready, bus.req0_ready, bus.rsp_valid} !== 3'b000)
         $display("FAIL midrun_after_release got r1=%b r0=%b v=%b exp 0 0 0",
                  bus.req1_ready, bus.req0_ready, bus.rsp_valid);
      else passed++;
   endtask

   task automatic test_opcodes();
      op_t   v_op  [9];
      data_t v_dat [9];
      cnt_t  v_cnt [9];
      data_t v_exp [9];
      v_op  = '{ROL,      SLL,      ROR,      SRA,      SRA,      ROL,      SLL,      ROR,      SRA};
      v_dat = '{16'h8001, 16'h8001, 16'h0001, 16'h8000, 16'h4000, 16'hBEEF, 16'h00F1, 16'h5A5A, 16'h8421};
      v_cnt = '{4'd1,     4'd1,     4'd4,     4'd15,    4'd14,    4'd0,     4'd0,     4'd0,     4'd0};
      v_exp = '{16'h0003, 16'h0002, 16'h1000, 16'hFFFF, 16'h0001, 16'hBEEF, 16'h00F1, 16'h5A5A, 16'h8421};
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         bus.req0_valid = 1'b1;
         bus.req0_op    = v_op[i];
         bus.req0_data  = v_dat[i];
         bus.req0_cnt   = v_cnt[i];
         #1;
         checks++;
         if ({bus.req1_ready, bus.req0_ready} !== 2'b01)
            $display("FAIL opcode_ready[%0d] got %b%b exp 01", i, bus.req1_ready, bus.req0_ready);
         else passed++;
         tick();
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== v_exp[i])
            $display("FAIL opcode_result[%0d] got v=%b id=%b d=%h exp 1 0 %h",
                     i, bus.rsp_valid, bus.rsp_id, bus.rsp_data, v_exp[i]);
         else passed++;
      end
      bus.req0_valid = 1'b0;
      tick();
   endtask

   task automatic test_contention();
      data_t e0, e1;
      pulse_reset();
      bus.rsp_ready  = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req0_op    = ROL;
      bus.req0_data  = 16'h1234;
      bus.req0_cnt   = 4'd4;
      bus.req1_valid = 1'b1;
      bus.req1_op    = SLL;
      bus.req1_data  = 16'h00FF;
      bus.req1_cnt   = 4'd8;
      e0 = ref_result(ROL, 16'h1234, 4'd4);
      e1 = ref_result(SLL, 16'h00FF, 4'd8);
      for (int k = 0; k < 6; k++) begin
         #1;
         checks++;
         if ({bus.req1_ready, bus.req0_ready} !== ((k % 2 == 0) ? 2'b01 : 2'b10))
            $display("FAIL contention_grant[%0d] got %b%b", k, bus.req1_ready, bus.req0_ready);
         else passed++;
         tick();
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'(k % 2) ||
             bus.rsp_data !== ((k % 2 == 0) ? e0 : e1))
            $display("FAIL contention_rsp[%0d] got v=%b id=%b d=%h exp 1 %0d %h",
                     k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, k % 2,
                     (k % 2 == 0) ? e0 : e1);
         else passed++;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      bus.rsp_ready  = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req0_op    = ROL;
      bus.req0_data  = 16'h1234;
      bus.req0_cnt   = 4'd0;
      tick();
      bus.req0_valid = 1'b0;
      bus.rsp_ready  = 1'b0;
      bus.req1_valid = 1'b1;
      bus.req1_op    = SRA;
      bus.req1_data  = 16'h8000;
      bus.req1_cnt   = 4'd3;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h1234 || bus.rsp_id !== 1'b0 ||
             {bus.req1_ready, bus.req0_ready} !== 2'b00)
            $display("FAIL stall_hold[%0d] got v=%b d=%h id=%b r=%b%b exp 1 1234 0 00",
                     i, bus.rsp_valid, bus.rsp_data, bus.rsp_id,
                     bus.req1_ready, bus.req0_ready);
         else passed++;
         tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b10)
         $display("FAIL stall_release_ready got %b%b exp 10", bus.req1_ready, bus.req0_ready);
      else passed++;
      tick();
      bus.req1_valid = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_data !== 16'hF000)
         $display("FAIL stall_release_rsp got v=%b id=%b d=%h exp 1 1 f000",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_data);
      else passed++;
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0)
         $display("FAIL drain_clear got v=%b exp 0", bus.rsp_valid);
      else passed++;
   endtask

   task automatic test_single();
      data_t exp;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.req1_valid = 1'b1;
         bus.req1_op    = op_t'(2'(i));
         bus.req1_data  = 16'($urandom);
         bus.req1_cnt   = 4'($urandom);
         exp = ref_result(bus.req1_op, bus.req1_data, bus.req1_cnt);
         #1;
         checks++;
         if ({bus.req1_ready, bus.req0_ready} !== 2'b10)
            $display("FAIL single_ready[%0d] got %b%b exp 10", i, bus.req1_ready, bus.req0_ready);
         else passed++;
         tick();
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_data !== exp)
            $display("FAIL single_rsp[%0d] got v=%b id=%b d=%h exp 1 1 %h",
                     i, bus.rsp_valid, bus.rsp_id, bus.rsp_data, exp);
         else passed++;
      end
      bus.req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_random();
      bit    m_valid, m_id, m_prio, pend0, pend1, v0, v1, sf, g, e0, e1;
      data_t m_data;
      int    accepted, received;
      idle_inputs();
      pulse_reset();
      m_valid = 0; m_id = 0; m_prio = 0; m_data = '0;
      pend0 = 0; pend1 = 0;
      accepted = 0; received = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         if (!pend0) begin
            if ($urandom_range(0, 2) != 0) begin
               bus.req0_valid = 1'b1;
               bus.req0_op    = op_t'(2'($urandom));
               bus.req0_data  = 16'($urandom);
               bus.req0_cnt   = 4'($urandom);
               pend0 = 1;
            end else bus.req0_valid = 1'b0;
         end
         if (!pend1) begin
            if ($urandom_range(0, 2) != 0) begin
               bus.req1_valid = 1'b1;
               bus.req1_op    = op_t'(2'($urandom));
               bus.req1_data  = 16'($urandom);
               bus.req1_cnt   = 4'($urandom);
               pend1 = 1;
            end else bus.req1_valid = 1'b0;
         end
         #1;
         v0 = pend0;
         v1 = pend1;
         sf = !m_valid || bus.rsp_ready;
         g  = (v0 && v1) ? m_prio : v1;
         e0 = sf && v0 && !g;
         e1 = sf && v1 && g;
         checks++;
         if ({bus.req1_ready, bus.req0_ready} !== {e1, e0})
            $display("FAIL rand_ready[%0d] got %b%b exp %b%b",
                     cyc, bus.req1_ready, bus.req0_ready, e1, e0);
         else passed++;
         checks++;
         if (bus.rsp_valid !== m_valid ||
             (m_valid && (bus.rsp_id !== m_id || bus.rsp_data !== m_data)))
            $display("FAIL rand_rsp[%0d] got v=%b id=%b d=%h exp %b %b %h",
                     cyc, bus.rsp_valid, bus.rsp_id, bus.rsp_data, m_valid, m_id, m_data);
         else passed++;
         if (bus.rsp_valid && bus.rsp_ready) received++;
         if (sf && (v0 || v1)) begin
            m_data  = g ? ref_result(bus.req1_op, bus.req1_data, bus.req1_cnt)
                        : ref_result(bus.req0_op, bus.req0_data, bus.req0_cnt);
            m_id    = g;
            m_valid = 1;
            m_prio  = !g;
            if (g) pend1 = 0; else pend0 = 0;
            accepted++;
         end else if (m_valid && bus.rsp_ready) begin
            m_valid = 0;
         end
         tick();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp_ready  = 1'b1;
      #1;
      if (bus.rsp_valid) received++;
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0 || received != accepted)
         $display("FAIL rand_transfers got v=%b received=%0d exp v=0 received=%0d",
                  bus.rsp_valid, received, accepted);
      else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      test_reset();
      test_reset_midrun();
      test_opcodes();
      test_contention();
      test_backpressure();
      test_single();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
